// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder:
//   - default geometry (address width, word width, depth, read latency)
//   - scrub/ready FSM state encoding
//   - byte_merge(): applies a byte-lane mask of new data onto an old word.
//     It is used both for array writes and for the write-first bypass path.
//     The function is sized to DEF_DATA_W.
package dmem_responder_pkg;

   localparam int DEF_ADDR_W     = 8;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_DEPTH      = 256;
   localparam int DEF_READ_LAT   = 1;
   localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      SCRUB = 2'd1,
      READY = 2'd2
   } state_t;

   function automatic logic [DEF_DATA_W-1:0] byte_merge(
      input logic [DEF_DATA_W-1:0]     old_word,
      input logic [DEF_DATA_W-1:0]     new_word,
      input logic [BYTES_PER_WORD-1:0] mask
   );
      logic [DEF_DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Core-to-data-memory bus.
//   master (core side)     : drives strobes, addresses, write data and mask;
//                            receives dout_o and ready_o.
//   slave  (responder side): the reverse.
//   csb_write_i / csb_read_i are active-low strobes.
interface dmem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  csb_write_i;
   logic [DATA_W/8-1:0]   wmask_i;
   logic [ADDR_W-1:0]     waddr_i;
   logic [DATA_W-1:0]     din_i;
   logic                  csb_read_i;
   logic [ADDR_W-1:0]     raddr_i;
   logic [DATA_W-1:0]     dout_o;
   logic                  ready_o;

   modport master (
      output csb_write_i, wmask_i, waddr_i, din_i, csb_read_i, raddr_i,
      input  dout_o, ready_o
   );

   modport slave (
      input  csb_write_i, wmask_i, waddr_i, din_i, csb_read_i, raddr_i,
      output dout_o, ready_o
   );
endinterface

// File: rtl/dmem_responder_rd_pipe.sv
// dmem_responder_rd_pipe
//   READ_LAT-deep delay line of {valid, data} for read responses.
//   Ports:
//     clk_i, reset_i : clock, asynchronous active-high reset (clears valids)
//     in_vld         : read accepted this cycle
//     in_data        : word read from the array (or bypass) this cycle
//     dout           : read data; updates only when the last stage is valid,
//                      otherwise holds the previous value
module dmem_responder_rd_pipe #(
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] dout
);

   logic [READ_LAT-1:0] vld_p;
   logic [DATA_W-1:0]   data_p [READ_LAT];
   logic [DATA_W-1:0]   hold;

   // Control: valid shift register and the held output word, both cleared
   // by reset so dout drops to zero immediately and in-flight reads vanish.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         vld_p <= '0;
         hold  <= '0;
      end else begin
         vld_p[0] <= in_vld;
         for (int k = 1; k < READ_LAT; k++) vld_p[k] <= vld_p[k-1];
         hold <= dout;
      end
   end

   // Data stages carry no reset; they are qualified by vld_p.
   always_ff @(posedge clk_i) begin
      data_p[0] <= in_data;
      for (int k = 1; k < READ_LAT; k++) data_p[k] <= data_p[k-1];
   end

   // Last stage is itself a register, so dout is a flop-to-output mux.
   assign dout = vld_p[READ_LAT-1] ? data_p[READ_LAT-1] : hold;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the core's dmem port. After every reset it
//   scrubs the whole array to zero (INIT -> SCRUB -> READY), then accepts
//   byte-masked writes and fixed-latency pipelined reads.
//   Ports:
//     clk_i   : clock
//     reset_i : asynchronous active-high reset
//     bus     : dmem_responder_if.slave (strobes, addresses, data, ready)
//   Build option:
//     DMEM_BYPASS_EN defined   -> same-cycle same-address read returns the
//                                 merged (post-write) word (write-first)
//     DMEM_BYPASS_EN undefined -> read returns the pre-write word (read-first)
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int READ_LAT = DEF_READ_LAT
) (
   input  logic             clk_i,
   input  logic             reset_i,
   dmem_responder_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              ready_q;
   logic              scrub_we;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_en, rd_en;
   logic              wr_in_range, rd_in_range;
   logic [DATA_W-1:0] old_word, rd_word;

   // FSM state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= INIT;
         cnt     <= '0;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_q <= (state_nxt == READY);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      scrub_we  = 1'b0;
      case (state)
         INIT: begin
            cnt_nxt   = '0;
            state_nxt = SCRUB;
         end
         SCRUB: begin
            scrub_we = 1'b1;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == LAST_ADDR) state_nxt = READY;
         end
         READY:   state_nxt = READY;
         default: state_nxt = INIT;
      endcase
   end

   // Requests only count once the scrub is done; out-of-range writes drop.
   assign wr_in_range = ({1'b0, bus.waddr_i} < DEPTH_V);
   assign rd_in_range = ({1'b0, bus.raddr_i} < DEPTH_V);
   assign wr_en       = ready_q && !bus.csb_write_i && wr_in_range;
   assign rd_en       = ready_q && !bus.csb_read_i;

   always_ff @(posedge clk_i) begin
      if (scrub_we)
         mem[cnt] <= '0;
      else if (wr_en)
         mem[bus.waddr_i] <= byte_merge(mem[bus.waddr_i], bus.din_i, bus.wmask_i);
   end

   assign old_word = rd_in_range ? mem[bus.raddr_i] : '0;

`ifdef DMEM_BYPASS_EN
   assign rd_word = (wr_en && (bus.waddr_i == bus.raddr_i))
                    ? byte_merge(old_word, bus.din_i, bus.wmask_i)
                    : old_word;
`else
   assign rd_word = old_word;
`endif

   dmem_responder_rd_pipe #(
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT)
   ) u_rd_pipe (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .in_vld  (rd_en),
      .in_data (rd_word),
      .dout    (bus.dout_o)
   );

   assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Randomized and directed bench for dmem_responder (default geometry,
//   READ_LAT=1). A word-array reference model tracks memory contents and
//   the expected read data; each scenario task compares DUT outputs to it.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 256;
`ifdef DMEM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_responder dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] ref_dout;

   // Each lane of the result is either the new lane or the old lane.
   function automatic logic [DW-1:0] lane_select(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [3:0] m);
      logic [DW-1:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return r;
   endfunction

   task automatic idle();
      bus.csb_write_i = 1'b1;
      bus.csb_read_i  = 1'b1;
      bus.wmask_i     = '0;
      bus.waddr_i     = '0;
      bus.din_i       = '0;
      bus.raddr_i     = '0;
   endtask

   // Drive one cycle of requests and advance the reference model (ready assumed).
   task automatic cycle(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic [3:0] m, input bit re, input logic [AW-1:0] ra);
      logic [DW-1:0] exp_rd;
      bus.csb_write_i = ~we;
      bus.waddr_i     = wa;
      bus.din_i       = d;
      bus.wmask_i     = m;
      bus.csb_read_i  = ~re;
      bus.raddr_i     = ra;
      if (re) begin
         exp_rd = (int'(ra) < DEPTH) ? ref_mem[ra] : '0;
         if (BYPASS && we && wa == ra) exp_rd = lane_select(exp_rd, d, m);
         ref_dout = exp_rd;
      end
      if (we && int'(wa) < DEPTH) ref_mem[wa] = lane_select(ref_mem[wa], d, m);
      @(posedge clk); #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_dout = '0;
   endtask

   task automatic test_reset();
      int n;
      idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.dout_o !== '0) begin
         failures++;
         $display("FAIL reset_state: ready=%b dout=%h required ready=0 dout=0", bus.ready_o, bus.dout_o);
      end
      rst = 1'b0;
      clear_model();
      n = 0;
      while (bus.ready_o !== 1'b1 && n < 2*DEPTH + 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != DEPTH + 1) begin
         failures++;
         $display("FAIL scrub_latency: ready after %0d cycles required %0d", n, DEPTH + 1);
      end
      cycle(0, '0, '0, '0, 1, 8'h00);
      checks++;
      if (bus.dout_o !== 32'h0) begin
         failures++;
         $display("FAIL read_0x00_after_scrub: got %h required 00000000", bus.dout_o);
      end
      cycle(0, '0, '0, '0, 1, 8'hFF);
      checks++;
      if (bus.dout_o !== 32'h0) begin
         failures++;
         $display("FAIL read_0xFF_after_scrub: got %h required 00000000", bus.dout_o);
      end
      idle();
   endtask

   task automatic test_full_write();
      cycle(1, 8'h10, 32'hDEADBEEF, 4'b1111, 0, '0);
      cycle(0, '0, '0, '0, 1, 8'h10);
      checks++;
      if (bus.dout_o !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL full_write: got %h required DEADBEEF", bus.dout_o);
      end
      idle();
   endtask

   task automatic test_partial_write();
      cycle(1, 8'h20, 32'h11223344, 4'b1111, 0, '0);
      cycle(1, 8'h20, 32'hAABBCCDD, 4'b0101, 0, '0);
      cycle(1, 8'h20, 32'hFFFFFFFF, 4'b0000, 0, '0);
      cycle(0, '0, '0, '0, 1, 8'h20);
      checks++;
      if (bus.dout_o !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL partial_write: got %h required 11BB33DD", bus.dout_o);
      end
      idle();
   endtask

   task automatic test_same_addr();
      logic [DW-1:0] exp_first;
      exp_first = BYPASS ? 32'h12345678 : 32'h00000000;
      cycle(1, 8'h30, 32'h12345678, 4'b1111, 1, 8'h30);
      checks++;
      if (bus.dout_o !== exp_first) begin
         failures++;
         $display("FAIL same_addr_rw: got %h required %h", bus.dout_o, exp_first);
      end
      cycle(0, '0, '0, '0, 1, 8'h30);
      checks++;
      if (bus.dout_o !== 32'h12345678) begin
         failures++;
         $display("FAIL same_addr_followup: got %h required 12345678", bus.dout_o);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_v [3];
      exp_v[0] = 32'hA; exp_v[1] = 32'hB; exp_v[2] = 32'hC;
      for (int i = 0; i < 3; i++) cycle(1, AW'(i + 1), exp_v[i], 4'b1111, 0, '0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, '0, '0, '0, 1, AW'(i + 1));
         checks++;
         if (bus.dout_o !== exp_v[i]) begin
            failures++;
            $display("FAIL back_to_back[%0d]: got %h required %h", i, bus.dout_o, exp_v[i]);
         end
      end
      idle();
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (bus.dout_o !== 32'hC) begin
            failures++;
            $display("FAIL dout_hold: got %h required 0000000C", bus.dout_o);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         cycle(bit'($urandom_range(0, 1)), AW'(8'h40 + $urandom_range(0, 15)), DW'($urandom),
               4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
               AW'(8'h40 + $urandom_range(0, 15)));
         checks++;
         if (bus.dout_o !== ref_dout || bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL random[%0d]: dout=%h ready=%b required dout=%h ready=1",
                     i, bus.dout_o, bus.ready_o, ref_dout);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_read_and_scrub();
      int n;
      cycle(1, 8'h44, 32'hCAFEF00D, 4'b1111, 0, '0);
      cycle(0, '0, '0, '0, 1, 8'h44);
      checks++;
      if (bus.dout_o !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL pre_reset_read: got %h required CAFEF00D", bus.dout_o);
      end
      // Read strobe still asserted: reset lands mid-read, between edges.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.dout_o !== '0 || bus.ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_read: dout=%h ready=%b required dout=0 ready=0", bus.dout_o, bus.ready_o);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // Requests during scrub must be ignored.
      bus.csb_write_i = 1'b0; bus.waddr_i = 8'h50; bus.din_i = 32'h5A5A5A5A; bus.wmask_i = 4'hF;
      bus.csb_read_i  = 1'b0; bus.raddr_i = 8'h44;
      repeat (101) @(posedge clk);
      #1;
      checks++;
      if (bus.dout_o !== '0 || bus.ready_o !== 1'b0) begin
         failures++;
         $display("FAIL scrub_ignores_requests: dout=%h ready=%b required dout=0 ready=0", bus.dout_o, bus.ready_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.dout_o !== '0 || bus.ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_scrub: dout=%h ready=%b required dout=0 ready=0", bus.dout_o, bus.ready_o);
      end
      idle();
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      n = 0;
      while (bus.ready_o !== 1'b1 && n < 2*DEPTH + 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != DEPTH + 1) begin
         failures++;
         $display("FAIL rescrub_latency: ready after %0d cycles required %0d", n, DEPTH + 1);
      end
      cycle(0, '0, '0, '0, 1, 8'h44);
      checks++;
      if (bus.dout_o !== 32'h0) begin
         failures++;
         $display("FAIL rescrub_clears: got %h required 00000000", bus.dout_o);
      end
      cycle(0, '0, '0, '0, 1, 8'h50);
      checks++;
      if (bus.dout_o !== 32'h0) begin
         failures++;
         $display("FAIL scrub_write_dropped: got %h required 00000000", bus.dout_o);
      end
      idle();
   endtask

   initial begin
      idle();
      clear_model();
      test_reset();
      test_full_write();
      test_partial_write();
      test_same_addr();
      test_back_to_back();
      test_random();
      test_reset_mid_read_and_scrub();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that sits on the far side of the core's dmem port. It accepts the core's active-low write and read strobes, performs byte-masked writes, and returns read data after a fixed latency. After every reset it runs a scrub state machine that clears the whole array, and it reports readiness while doing so. It is used as the dmem model in core-level simulation and as the wrapper around the data SRAM at top level.

Parameters:
ADDR_W, 8, word-address width; matches dmem_waddr_o and dmem_raddr_o.
DATA_W, 32, word width; must be a multiple of 8.
DEPTH, 256, number of words; must be at most 2**ADDR_W.
READ_LAT, 1, read latency in cycles, from strobe-sample edge to dout update; must be at least 1.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_i  in  1  reset, asynchronous, active-high.
csb_write_i  in  1  write strobe, active-low.
wmask_i  in  DATA_W/8  byte-lane write enable; bit i covers din_i[8i+7:8i].
waddr_i  in  ADDR_W  write word address.
din_i  in  DATA_W  write data.
csb_read_i  in  1  read strobe, active-low.
raddr_i  in  ADDR_W  read word address.
dout_o  out  DATA_W  read data.
ready_o  out  1  high once scrub is complete and requests are accepted.

Behaviour:
- Reset (asynchronous assert, any cycle, including mid-scrub or mid-read):
  - state=INIT, scrub counter=0, ready_o=0, dout_o=0.
  - Read pipeline valid bits cleared; in-flight reads are discarded.
  - Array contents are don't-care until scrub finishes.
- FSM INIT (one cycle):
  - Clears the scrub counter, then goes to SCRUB.
- FSM SCRUB:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt==DEPTH-1 is written, goes to READY.
  - Scrub takes DEPTH cycles; all requests are ignored (no write, no read response).
- FSM READY:
  - ready_o=1, registered; rises on the edge that leaves SCRUB.
  - Stays in READY until reset.
- Write (READY and csb_write_i==0, sampled at edge N):
  - For each i with wmask_i[i]=1, mem[waddr_i] byte i <= din_i byte i.
  - Bytes with the mask bit clear are unchanged.
  - wmask_i==0 is a legal no-op.
- Read (READY and csb_read_i==0, sampled at edge N):
  - dout_o takes mem[raddr_i] at edge N+READ_LAT-1.
  - With READ_LAT=1, data is visible in the cycle after the strobe.
  - One read is accepted per cycle, fully pipelined; back-to-back reads return in order, one per cycle.
- No read: dout_o holds its last value; it is not cleared.
- Out of range (address >= DEPTH):
  - Writes are dropped.
  - Reads return 0.
- Simultaneous read and write to the same address in the same cycle: behaviour is set by DMEM_BYPASS_EN (see Optional Feature).
- Simultaneous read and write to different addresses: both proceed independently.
- Strobes asserted while ready_o=0: ignored with no side effects; the read pipeline stays empty.

Optional Feature:
DMEM_BYPASS_EN
- Defined (write-first): on a same-cycle, same-address read and write, the read returns the merged word. Lanes with wmask=1 come from din_i; the other lanes come from the old word.
- Undefined (read-first): the read returns the pre-write word.
- Write behaviour is identical in both cases.

Decomposition:
- Package dmem_pkg:
  - Default ADDR_W, DATA_W, DEPTH, READ_LAT.
  - BYTES_PER_WORD=DATA_W/8.
  - FSM state enum {INIT, SCRUB, READY}.
  - A byte-merge function (old, new, mask) -> word, used for writes and for the bypass path.
- Sub-module dmem_rd_pipe:
  - READ_LAT-deep delay line of {valid, data}.
  - Asynchronously cleared by reset_i.
  - Drives dout_o only when the last-stage valid bit is set.

Test Plan:
1. Reset for 3 cycles, then release -> ready_o=0 for exactly DEPTH+1 cycles, then 1. Reads of addr 0x00 and 0xFF return 0x00000000.
2. Write addr 0x10, din 0xDEADBEEF, wmask 4'b1111; then read 0x10 -> dout_o=0xDEADBEEF one cycle after the read strobe (READ_LAT=1).
3. With mem[0x20]=0x11223344, write din 0xAABBCCDD with wmask 4'b0101 -> a read of 0x20 returns 0x11BB33DD.
4. With mem[0x30]=0x0, read and write 0x30 in the same cycle with din 0x12345678, wmask 4'b1111 -> dout_o=0x12345678 if DMEM_BYPASS_EN is defined, 0x00000000 if not. A following read returns 0x12345678 in both builds.
5. Reads to 0x01, 0x02, 0x03 on consecutive cycles (values 0xA, 0xB, 0xC) -> dout_o=0xA, 0xB, 0xC on three consecutive cycles. Then strobes deasserted -> dout_o holds 0xC.
6. Assert reset_i mid-scrub (cnt=100) and mid-read -> dout_o=0 and ready_o=0 immediately. Scrub restarts from 0 and ready_o rises DEPTH+1 cycles after release.
